// File: rtl/rv32i_fetch_pkg.sv
// rv32i_fetch_pkg
//   Shared definitions for the RV32I fetch stage: reset PC default, the
//   fetch FSM state encoding and the PC incrementer.
package rv32i_fetch_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // FETCH: strobe out on pc, accept ack into decode or hold buffer
    // HOLD : a word is parked in the hold buffer while decode stalls
    // DRAIN: squashed request still outstanding; wait for its ack
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Wraps modulo 2^32 by construction.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/rv32i_fetch.sv
// rv32i_fetch
//   Fetch stage. Owns the PC, issues one instruction fetch at a time over a
//   stb/ack port and hands {inst, pc} to decode with o_ce as valid.
//   Redirects from writeback (priority) or the ALU squash any in-flight fetch.
// Ports
//   i_clk, i_rst_n          clock, async active-low reset
//   o_iaddr, o_stb_inst     fetch request address / strobe
//   i_ack_inst, i_inst      memory ack and instruction word (valid with ack)
//   i_writeback_change_pc/_next_pc   writeback redirect
//   i_alu_change_pc/_next_pc         ALU redirect
//   i_stall                 decode cannot accept this cycle
//   o_inst, o_pc, o_ce      word to decode, its PC, valid
module rv32i_fetch
    import rv32i_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_iaddr,
    output logic        o_stb_inst,
    input  logic        i_ack_inst,
    input  logic [31:0] i_inst,
    input  logic        i_writeback_change_pc,
    input  logic [31:0] i_writeback_next_pc,
    input  logic        i_alu_change_pc,
    input  logic [31:0] i_alu_next_pc,
    input  logic        i_stall,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_ce
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  opc_q, opc_d;
    logic         ce_q, ce_d;
    logic [31:0]  buf_inst_q, buf_inst_d;
    logic [31:0]  buf_pc_q, buf_pc_d;

    logic         redirect;
    logic [31:0]  target;

    assign redirect = i_writeback_change_pc | i_alu_change_pc;
    assign target   = i_writeback_change_pc ? i_writeback_next_pc : i_alu_next_pc;

    // State register and all datapath flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= PC_RESET;
            drain_addr_q <= '0;
            inst_q       <= '0;
            opc_q        <= '0;
            ce_q         <= 1'b0;
            buf_inst_q   <= '0;
            buf_pc_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            inst_q       <= inst_d;
            opc_q        <= opc_d;
            ce_q         <= ce_d;
            buf_inst_q   <= buf_inst_d;
            buf_pc_q     <= buf_pc_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    // Request is squashed; if it has not completed we must
                    // still wait for its ack before issuing the new one.
                    state_d = i_ack_inst ? ST_FETCH : ST_DRAIN;
                end else if (i_ack_inst && i_stall) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect || !i_stall) state_d = ST_FETCH;
            end
            ST_DRAIN: begin
                if (i_ack_inst) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Datapath next values.
    always_comb begin
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        inst_d       = inst_q;
        opc_d        = opc_q;
        ce_d         = ce_q;
        buf_inst_d   = buf_inst_q;
        buf_pc_d     = buf_pc_q;
        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    // Redirect beats stall: the squashed word never reaches decode.
                    pc_d = target;
                    ce_d = 1'b0;
                    if (!i_ack_inst) drain_addr_d = pc_q;
                end else if (i_ack_inst) begin
                    if (!i_stall) begin
                        inst_d = i_inst;
                        opc_d  = pc_q;
                        ce_d   = 1'b1;
                    end else begin
                        buf_inst_d = i_inst;
                        buf_pc_d   = pc_q;
                    end
                    pc_d = pc_inc(pc_q);
                end else if (!i_stall) begin
                    ce_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d = target;
                    ce_d = 1'b0;
                end else if (!i_stall) begin
                    inst_d = buf_inst_q;
                    opc_d  = buf_pc_q;
                    ce_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                ce_d = 1'b0;
                // Latest redirect wins; the drained data is dropped.
                if (redirect) pc_d = target;
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        o_stb_inst = (state_q != ST_HOLD);
        o_iaddr    = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    end

    assign o_inst = inst_q;
    assign o_pc   = opc_q;
    assign o_ce   = ce_q;

endmodule

// File: tb/tb_rv32i_fetch.sv
// tb_rv32i_fetch
//   Directed bench for rv32i_fetch. Memory returns inst = addr>>2 (mem[i]=i).
module tb_rv32i_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] o_iaddr;
    logic        o_stb_inst;
    logic        i_ack_inst;
    logic [31:0] i_inst;
    logic        wb_chg, alu_chg, stall;
    logic [31:0] wb_pc, alu_pc;
    logic [31:0] o_inst, o_pc;
    logic        o_ce;

    int checks = 0;
    int errors = 0;

    rv32i_fetch #(.PC_RESET(32'h0)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_iaddr(o_iaddr), .o_stb_inst(o_stb_inst),
        .i_ack_inst(i_ack_inst), .i_inst(i_inst),
        .i_writeback_change_pc(wb_chg), .i_writeback_next_pc(wb_pc),
        .i_alu_change_pc(alu_chg), .i_alu_next_pc(alu_pc),
        .i_stall(stall),
        .o_inst(o_inst), .o_pc(o_pc), .o_ce(o_ce)
    );

    assign i_inst = {2'b00, o_iaddr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        e_stb;
        logic [31:0] e_iaddr;
        logic        e_ce;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        ack;
        logic        stall;
        logic        wb;
        logic [31:0] wbpc;
        logic        alu;
        logic [31:0] alupc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic es, logic [31:0] ea, logic ec, logic [31:0] ep,
                                logic [31:0] ei, logic a, logic s, logic w,
                                logic [31:0] wp, logic al, logic [31:0] ap);
        vec_t v;
        v.e_stb = es; v.e_iaddr = ea; v.e_ce = ec; v.e_pc = ep; v.e_inst = ei;
        v.ack = a; v.stall = s; v.wb = w; v.wbpc = wp; v.alu = al; v.alupc = ap;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic s, input logic w, input logic [31:0] wp,
                         input logic al, input logic [31:0] ap);
        i_ack_inst = a; stall = s; wb_chg = w; wb_pc = wp; alu_chg = al; alu_pc = ap;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #2;

        // Reset state
        chk("rst_ce", {31'b0, o_ce}, 32'h0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_inst", o_inst, 32'h0);
        chk("rst_stb", {31'b0, o_stb_inst}, 32'h1);
        chk("rst_iaddr", o_iaddr, 32'h0);

        // Streaming: ack every cycle starting one cycle after the first strobe
        do_reset();
        chk("s0_iaddr", o_iaddr, 32'h0);
        chk("s0_ce", {31'b0, o_ce}, 32'h0);
        for (int n = 1; n < 10; n++) begin
            step();
            chk("s_iaddr", o_iaddr, 32'((n - 1) * 4));
            chk("s_stb", {31'b0, o_stb_inst}, 32'h1);
            if (n >= 2) begin
                chk("s_ce", {31'b0, o_ce}, 32'h1);
                chk("s_pc", o_pc, 32'((n - 2) * 4));
                chk("s_inst", o_inst, 32'(n - 2));
            end else begin
                chk("s_ce", {31'b0, o_ce}, 32'h0);
            end
            i_ack_inst = 1'b1;
        end

        // Table: stall/hold, drain, dual redirect, redirect in hold, wraparound
        //            stb iaddr        ce pc           inst         | ack st wb wbpc          alu alupc
        vq.push_back(mk(1, 32'h0,     0, 0, 0,                   0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h0,     0, 0, 0,                   1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h4,     1, 32'h0, 32'h0,           1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h8,     1, 32'h4, 32'h1,           1, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 32'h0,     1, 32'h4, 32'h1,           0, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 32'h0,     1, 32'h4, 32'h1,           0, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 32'h0,     1, 32'h4, 32'h1,           0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'hC,     1, 32'h8, 32'h2,           0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'hC,     0, 0, 0,                   1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h10,    1, 32'hC, 32'h3,           0, 0, 0, 0, 1, 32'h100));
        vq.push_back(mk(1, 32'h10,    0, 0, 0,                   0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h10,    0, 0, 0,                   0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h10,    0, 0, 0,                   1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h100,   0, 0, 0,                   1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h104,   1, 32'h100, 32'h40,        1, 0, 1, 32'h200, 1, 32'h300));
        vq.push_back(mk(1, 32'h200,   0, 0, 0,                   1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h204,   1, 32'h200, 32'h80,        1, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 32'h0,     1, 32'h200, 32'h80,        0, 1, 0, 0, 1, 32'h400));
        vq.push_back(mk(1, 32'h400,   0, 0, 0,                   0, 1, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h400,   0, 0, 0,                   1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h404,   1, 32'h400, 32'h100,       1, 1, 0, 0, 1, 32'h500));
        vq.push_back(mk(1, 32'h500,   0, 0, 0,                   0, 0, 1, 32'hFFFF_FFFC, 0, 0));
        vq.push_back(mk(1, 32'h500,   0, 0, 0,                   0, 0, 0, 0, 1, 32'h600));
        vq.push_back(mk(1, 32'h500,   0, 0, 0,                   1, 0, 1, 32'hFFFF_FFFC, 0, 0));
        vq.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0,               1, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 32'h0,     1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 0, 0, 0, 0, 0, 0));

        do_reset();
        for (int k = 0; k < vq.size(); k++) begin
            if (k != 0) step();
            chk($sformatf("v%0d_stb", k), {31'b0, o_stb_inst}, {31'b0, vq[k].e_stb});
            if (vq[k].e_stb) chk($sformatf("v%0d_iaddr", k), o_iaddr, vq[k].e_iaddr);
            chk($sformatf("v%0d_ce", k), {31'b0, o_ce}, {31'b0, vq[k].e_ce});
            if (vq[k].e_ce) begin
                chk($sformatf("v%0d_pc", k), o_pc, vq[k].e_pc);
                chk($sformatf("v%0d_inst", k), o_inst, vq[k].e_inst);
            end
            drive(vq[k].ack, vq[k].stall, vq[k].wb, vq[k].wbpc, vq[k].alu, vq[k].alupc);
        end

        // Reset asserted mid-DRAIN (pc is 0 in FETCH here)
        step();
        drive(1, 0, 0, 0, 1, 32'h800);   // redirect with ack: stay FETCH at 0x800
        step();
        drive(1, 0, 0, 0, 0, 0);         // fetch 0x800
        step();
        chk("pre_pc", o_pc, 32'h800);
        chk("pre_inst", o_inst, 32'h200);
        drive(0, 0, 0, 0, 1, 32'h700);   // squash pending 0x804 -> DRAIN
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("drain_iaddr", o_iaddr, 32'h804);
        chk("drain_ce", {31'b0, o_ce}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_iaddr", o_iaddr, 32'h0);
        chk("arst_stb", {31'b0, o_stb_inst}, 32'h1);
        chk("arst_pc", o_pc, 32'h0);
        chk("arst_inst", o_inst, 32'h0);
        chk("arst_ce", {31'b0, o_ce}, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("rs_iaddr", o_iaddr, 32'h0);
        i_ack_inst = 1'b1;
        step();
        chk("rs_ce", {31'b0, o_ce}, 32'h1);
        chk("rs_pc", o_pc, 32'h0);
        chk("rs_iaddr2", o_iaddr, 32'h4);
        i_ack_inst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
